fetch_decode_queue: RTL and testbench

// - Decouples fetch from decode in the pipelined datapath.
// - Captures {pc, pc+4, instruction} from the fetch unit into a small circular FIFO.
// - Presents the oldest entry to decode with a valid/ready handshake.
// - Discards all queued work when execute redirects the PC (branch/jal/jalr taken).
// - F_ready feeds the hazard unit, which drives the fetch unit's PC-register enable.

---
 rtl/fetch_decode_queue.sv | 97 +++++++++
 tb/tb_fetch_decode_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Circular fetch->decode queue holding {pc, pc+4, instr}; flushed on execute redirect.
// Optional same-cycle empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module fetch_decode_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       F_valid,
  input  logic [31:0]                F_pc_current,
  input  logic [31:0]                F_pc_plus_4,
  input  logic [31:0]                F_instr,
  output logic                       F_ready,
  output logic                       D_valid,
  output logic [31:0]                D_pc,
  output logic [31:0]                D_pc_plus_4,
  output logic [31:0]                D_instr,
  input  logic                       D_ready,
  input  logic                       E_flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          bypass;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & F_valid & ~E_flush;
`else
  assign bypass = 1'b0;
`endif

  // Ready is a function of registered occupancy only, so a full queue refuses even when popping.
  assign F_ready = ~full;
  assign push    = F_valid & F_ready & ~E_flush & ~(bypass & D_ready);
  assign pop     = ~empty & D_ready & ~E_flush;

  // Head presentation: stored entry, or live fetch data when bypassing an empty queue.
  always_comb begin
    head        = mem[rd_ptr];
    D_valid     = ~empty | bypass;
    D_pc        = '0;
    D_pc_plus_4 = '0;
    D_instr     = NOP_INSTR;
    if (bypass) begin
      head = '{pc: F_pc_current, pc_plus_4: F_pc_plus_4, instr: F_instr};
    end
    if (D_valid) begin
      D_pc        = head.pc;
      D_pc_plus_4 = head.pc_plus_4;
      D_instr     = head.instr;
    end
  end

  // Pointer and occupancy state; flush outranks any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || E_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; unread slots are never presented.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= '{pc: F_pc_current, pc_plus_4: F_pc_plus_4, instr: F_instr};
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (default build, DEPTH=4).
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        F_valid;
  logic [31:0] F_pc_current;
  logic [31:0] F_pc_plus_4;
  logic [31:0] F_instr;
  logic        F_ready;
  logic        D_valid;
  logic [31:0] D_pc;
  logic [31:0] D_pc_plus_4;
  logic [31:0] D_instr;
  logic        D_ready;
  logic        E_flush;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  fetch_decode_queue #(.DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .F_valid(F_valid), .F_pc_current(F_pc_current), .F_pc_plus_4(F_pc_plus_4),
    .F_instr(F_instr), .F_ready(F_ready),
    .D_valid(D_valid), .D_pc(D_pc), .D_pc_plus_4(D_pc_plus_4), .D_instr(D_instr),
    .D_ready(D_ready), .E_flush(E_flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0093;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive inputs just after a rising edge and let combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] pc, input logic dr, input logic fl);
    F_valid      = v;
    F_pc_current = pc;
    F_pc_plus_4  = pc + 32'd4;
    F_instr      = instr_of(pc);
    D_ready      = dr;
    E_flush      = fl;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] pc;
  logic        dr;
  logic        do_push;
  logic        do_pop;

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("rst_dvalid", 32'(D_valid), 32'd0);
    check("rst_fready", 32'(F_ready), 32'd1);
    check("rst_count",  32'(count),   32'd0);
    check("rst_dinstr", D_instr,      32'h13);
    check("rst_dpc",    D_pc,         32'h0);

    // In-order fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0);
      cyc();
      if (i == 0) begin
        check("lat1_dvalid", 32'(D_valid), 32'd1);
        check("lat1_dpc",    D_pc,         32'h8000_0000);
        check("lat1_dpc4",   D_pc_plus_4,  32'h8000_0004);
      end
    end
    check("full_count",  32'(count),   32'd4);
    check("full_fready", 32'(F_ready), 32'd0);
    drive(1'b1, 32'h8000_0010, 1'b0, 1'b0);
    cyc();
    check("overflow_count", 32'(count), 32'd4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("drain_dpc",   D_pc,    32'h8000_0000 + 32'(4 * i));
      check("drain_instr", D_instr, instr_of(32'h8000_0000 + 32'(4 * i)));
      cyc();
    end
    check("drain_count",  32'(count),   32'd0);
    check("drain_dvalid", 32'(D_valid), 32'd0);
    check("drain_nop",    D_instr,      32'h13);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    check("underflow_count", 32'(count), 32'd0);

    // Steady stream: occupancy stays 1, head advances by 4 each cycle
    drive(1'b1, 32'h8000_0200, 1'b1, 1'b0);
    cyc();
    check("stream_prime", 32'(count), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h8000_0200 + 32'(4 * i), 1'b1, 1'b0);
      check("stream_dpc", D_pc, 32'h8000_0200 + 32'(4 * (i - 1)));
      cyc();
      check("stream_count", 32'(count), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    check("stream_end", 32'(count), 32'd0);

    // Flush with three queued and one incoming
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0300 + 32'(4 * i), 1'b0, 1'b0);
      cyc();
    end
    check("preflush_count", 32'(count), 32'd3);
    drive(1'b1, 32'h8000_030C, 1'b1, 1'b1);
    cyc();
    check("flush_count",  32'(count),   32'd0);
    check("flush_dvalid", 32'(D_valid), 32'd0);
    check("flush_nop",    D_instr,      32'h13);
    drive(1'b1, 32'h8000_0100, 1'b0, 1'b0);
    cyc();
    check("postflush_dpc",   D_pc,       32'h8000_0100);
    check("postflush_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    check("postflush_empty", 32'(count), 32'd0);

    // Wrap: pushes every cycle, random decode stalls, scoreboard ordering
    pc = 32'h8000_0400;
    for (int i = 0; i < 10; i++) begin
      dr = 1'($urandom_range(0, 1));
      drive(1'b1, pc, dr, 1'b0);
      check("wrap_fready", 32'(F_ready), 32'(q.size() != 4));
      check("wrap_dvalid", 32'(D_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("wrap_dpc", D_pc, q[0]);
      do_push = (q.size() != 4);
      do_pop  = (q.size() != 0) && dr;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(pc);
        pc = pc + 32'd4;
      end
      cyc();
      check("wrap_count", 32'(count), 32'(q.size()));
    end
    while (q.size() != 0) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("wrap_drain_dpc", D_pc, q.pop_front());
      cyc();
    end
    check("wrap_final", 32'(count), 32'd0);

    // Reset mid-run with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0500 + 32'(4 * i), 1'b0, 1'b0);
      cyc();
    end
    check("prereset_count", 32'(count), 32'd3);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    #1;
    check("midrst_count",  32'(count),   32'd0);
    check("midrst_fready", 32'(F_ready), 32'd1);
    check("midrst_dvalid", 32'(D_valid), 32'd0);
    check("midrst_dpc",    D_pc,         32'h0);
    check("midrst_nop",    D_instr,      32'h13);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cyc();
    check("midrst_stale", 32'(D_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
